bus_xbar_arb: RTL and testbench
===============================

Name: bus_xbar_arb

Overview:
- Parametrised successor to the core's 2-master/3-slave combinational bus.
- Connects NUM_M masters to NUM_S memory-mapped slaves. Master 0 is the ex-stage load/store path; master 1 is pc_reg instruction fetch; further masters such as debug or DMA are optional.
- Registered arbitration is either fixed-priority or round-robin. Supports bus locking for atomic sequences, with a bounded lock timeout.
- Every access produces a one-cycle response phase with rvalid and a decode error flag.
- Sits in the top-level SoC between the core masters and rom/ram/gpio/etc.

Parameters:
- NUM_M, 2, number of masters (1..8).
- NUM_S, 4, number of slaves (1..16). Slave k owns addr[AW-1:AW-4]==k.
- AW, 32, address width.
- DW, 32, data width.
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
- LOCK_MAX, 16, maximum number of cycles a lock may be held before forced release (≥2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- m_req_i  in  NUM_M  access request, one bit per master; held with addr/we/wdata until gnt
- m_we_i  in  NUM_M  write enable per master
- m_lock_i  in  NUM_M  request bus lock at grant
- m_addr_i  in  NUM_M*AW  master addresses, master i at [i*AW +: AW]
- m_wdata_i  in  NUM_M*DW  master write data
- m_gnt_o  out  NUM_M  one-cycle pulse: request accepted this cycle
- m_hold_o  out  NUM_M  m_req_i[i] & ~m_gnt_o[i]; stalls the master's pipeline
- m_rvalid_o  out  NUM_M  response valid, exactly one cycle after gnt
- m_err_o  out  NUM_M  decode error, qualified by rvalid
- m_rdata_o  out  NUM_M*DW  read data, qualified by rvalid
- s_req_o  out  NUM_S  slave select strobe
- s_we_o  out  NUM_S  slave write enable
- s_addr_o  out  NUM_S*AW  slave address with the region nibble zeroed
- s_wdata_o  out  NUM_S*DW  slave write data
- s_rdata_i  in  NUM_S*DW  slave read data, valid the cycle after s_req_o

Behaviour:
- Reset (async, rst_n=0):
  - FSM → IDLE; rr_ptr=0; lock_r=0; lock_cnt=0.
  - All outputs 0, including m_hold_o.
  - Reset mid-access drops the access silently; no rvalid is produced after release.
- FSM states:
  - IDLE: no response pending.
  - RESP: response phase for access cur (owner cur_m, slave cur_s, cur_err).
- Accept (IDLE or RESP, same-cycle pipelining):
  - Eligible set E = m_req_i, or only the lock_owner bit when lock_r=1.
  - If E≠0, the winner w is chosen combinationally:
    - ARB_MODE 0: lowest index in E.
    - ARB_MODE 1: first index in E at or after rr_ptr, wrapping mod NUM_M.
  - Drive in the same cycle: m_gnt_o[w]=1; sel=addr_w[AW-1:AW-4]; if sel<NUM_S, s_req_o[sel]=1, s_we_o[sel]=m_we_i[w], s_addr_o[sel]={4'h0,addr_w[AW-5:0]}, s_wdata_o[sel]=wdata_w.
  - If sel≥NUM_S, no slave is strobed.
  - Registered at the clock edge: cur_m←w, cur_s←sel, cur_err←(sel≥NUM_S); rr_ptr←(w+1) mod NUM_M; next state RESP.
  - If E=0, next state is IDLE.
- RESP:
  - m_rvalid_o[cur_m]=1; m_err_o[cur_m]=cur_err.
  - m_rdata_o slot cur_m = cur_err ? 0 : s_rdata_i slot cur_s.
  - Writes also produce rvalid; rdata is don't-care for writes, but driven as above.
  - Non-owner rdata slots stay 0.
- Throughput: one access per cycle when requests are back-to-back. Read latency is gnt→rvalid = 1 cycle.
- Lock:
  - On grant of w with m_lock_i[w]=1 and lock_r=0: lock_r←1, lock_owner←w, lock_cnt←0.
  - While lock_r=1, lock_cnt increments every cycle.
  - Release lock_r←0 when the owner is granted with m_lock_i=0 (that access completes normally), or when lock_cnt==LOCK_MAX-1 (forced release; no error signalled).
  - When a grant and a timeout occur in the same cycle, the grant is honoured and the lock is released.
- rr_ptr updates only on grant. In fixed-priority mode, continuous requests from master 0 starve master 1 (legacy behaviour, by design).
- Unused upper address nibble values decode to error; there is no default slave.

Decomposition:
- Shared package/defines: AW/DW defaults (`MEM_ADDR_BUS/`MEM_BUS), region nibble position, ARB_MODE encodings, FSM state encodings.
- One sub-module, bus_rr_arbiter: NUM_M-wide request vector, mode, rr_ptr in; one-hot grant and encoded index out; purely combinational.
- Top module holds the FSM, lock logic and datapath muxing.

Test Plan:
1. Reset mid-access: assert rst_n=0 the cycle after gnt → no rvalid on any master; all outputs 0; rr_ptr=0.
2. ARB_MODE=0, m0 read 0x1000_0040 and m1 fetch 0x0000_0000 in the same cycle → m_gnt_o=01, m_hold_o=10, s_req_o=0010, s_addr_o[1]=0x0000_0040. Next cycle: m1 granted, m0 rvalid with s_rdata_i[1].
3. ARB_MODE=1, both masters requesting continuously for 6 cycles → grants alternate 0,1,0,1,0,1; each rvalid is one cycle after its grant.
4. Write to 0x5000_0010 with NUM_S=4 → s_req_o=0000; next cycle rvalid=1, err=1, rdata=0.
5. m1 issues 3 locked accesses followed by an unlocked one, with m0 requesting throughout → m0 held for all 4 m1 grants, then granted on the following cycle.
6. LOCK_MAX=4; m1 locks and then stops requesting → lock force-released after 4 cycles; m0 granted on the next cycle.

Source files
------------

// File: rtl/bus_xbar_arb_pkg.sv
// rtl/bus_xbar_arb_pkg.sv - shared constants, encodings and helpers for the bus crossbar arbiter
package bus_xbar_arb_pkg;

    // Default bus widths (memory address bus / memory data bus)
    localparam int DEF_AW   = 32;
    localparam int DEF_DW   = 32;

    // Width of the slave-select region nibble at the top of the address
    localparam int REGION_W = 4;

    // Arbitration mode encodings
    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

    // Response FSM
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    // Width of an encoded index over n items, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_rr_arbiter.sv
// rtl/bus_rr_arbiter.sv - combinational fixed-priority / round-robin request arbiter
//
// Ports:
//   req_i   in  NUM_M  eligible requests
//   mode_i  in  1      ARB_FIXED: lowest index wins; ARB_RR: first index at/after ptr_i
//   ptr_i   in  IW     round-robin start index
//   gnt_o   out NUM_M  one-hot grant
//   idx_o   out IW     encoded grant index
//   vld_o   out 1      some request was granted
module bus_rr_arbiter
    import bus_xbar_arb_pkg::*;
#(
    parameter int NUM_M = 2,
    parameter int IW    = 1
) (
    input  logic [NUM_M-1:0] req_i,
    input  logic             mode_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [NUM_M-1:0] gnt_o,
    output logic [IW-1:0]    idx_o,
    output logic             vld_o
);

    // Candidate examined at search position k; round-robin wraps at NUM_M
    function automatic int slot(input int k, input logic mode, input logic [IW-1:0] ptr);
        int j;
        j = (mode == ARB_FIXED) ? k : int'(ptr) + k;
        if (j >= NUM_M) begin
            j = j - NUM_M;
        end
        return j;
    endfunction

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        for (int k = 0; k < NUM_M; k++) begin
            if (!vld_o && req_i[slot(k, mode_i, ptr_i)]) begin
                vld_o                        = 1'b1;
                gnt_o[slot(k, mode_i, ptr_i)] = 1'b1;
                idx_o                        = IW'(slot(k, mode_i, ptr_i));
            end
        end
    end

endmodule

// File: rtl/bus_xbar_arb.sv
// rtl/bus_xbar_arb.sv - NUM_M x NUM_S bus crossbar with registered arbitration, locking and a one-cycle response phase
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   m_req_i/m_we_i/m_lock_i   in  NUM_M       per-master request, write enable, lock request
//   m_addr_i/m_wdata_i        in  NUM_M*AW/DW master address / write data, master i at slot i
//   m_gnt_o/m_hold_o          out NUM_M       accept pulse / stall (req & ~gnt)
//   m_rvalid_o/m_err_o        out NUM_M       response valid one cycle after gnt / decode error
//   m_rdata_o                 out NUM_M*DW    read data for the response owner, other slots 0
//   s_req_o/s_we_o            out NUM_S       slave strobe / write enable
//   s_addr_o/s_wdata_o        out NUM_S*AW/DW slave address (region nibble zeroed) / write data
//   s_rdata_i                 in  NUM_S*DW    slave read data, valid the cycle after s_req_o
module bus_xbar_arb
    import bus_xbar_arb_pkg::*;
#(
    parameter int NUM_M    = 2,
    parameter int NUM_S    = 4,
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int ARB_MODE = 0,
    parameter int LOCK_MAX = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_M-1:0]    m_req_i,
    input  logic [NUM_M-1:0]    m_we_i,
    input  logic [NUM_M-1:0]    m_lock_i,
    input  logic [NUM_M*AW-1:0] m_addr_i,
    input  logic [NUM_M*DW-1:0] m_wdata_i,
    output logic [NUM_M-1:0]    m_gnt_o,
    output logic [NUM_M-1:0]    m_hold_o,
    output logic [NUM_M-1:0]    m_rvalid_o,
    output logic [NUM_M-1:0]    m_err_o,
    output logic [NUM_M*DW-1:0] m_rdata_o,
    output logic [NUM_S-1:0]    s_req_o,
    output logic [NUM_S-1:0]    s_we_o,
    output logic [NUM_S*AW-1:0] s_addr_o,
    output logic [NUM_S*DW-1:0] s_wdata_o,
    input  logic [NUM_S*DW-1:0] s_rdata_i
);

    localparam int   MIW     = idx_width(NUM_M);
    localparam int   CW      = $clog2(LOCK_MAX) + 1;
    localparam logic RR_MODE = (ARB_MODE == int'(ARB_RR)) ? ARB_RR : ARB_FIXED;

    // Registered state
    state_e              state_q, state_d;
    logic [MIW-1:0]      cur_m_q, cur_m_d;
    logic [REGION_W-1:0] cur_s_q, cur_s_d;
    logic                cur_err_q, cur_err_d;
    logic [MIW-1:0]      rr_ptr_q, rr_ptr_d;
    logic                lock_q, lock_d;
    logic [MIW-1:0]      lock_owner_q, lock_owner_d;
    logic [CW-1:0]       lock_cnt_q, lock_cnt_d;

    // Arbitration
    logic [NUM_M-1:0]    owner_mask;
    logic [NUM_M-1:0]    elig;
    logic [NUM_M-1:0]    arb_gnt;
    logic [MIW-1:0]      win;
    logic                win_vld;

    // Winner datapath
    logic [AW-1:0]       win_addr;
    logic [DW-1:0]       win_wdata;
    logic                win_we;
    logic                win_lock;
    logic [REGION_W-1:0] sel;
    logic                sel_ok;
    logic [DW-1:0]       resp_data;

    assign owner_mask = NUM_M'(1) << lock_owner_q;

    // While locked only the owner may compete; reset masks everything so
    // that gnt/hold/strobes are all quiet while rst_n is low.
    always_comb begin
        elig = '0;
        if (rst_n) begin
            elig = lock_q ? (m_req_i & owner_mask) : m_req_i;
        end
    end

    bus_rr_arbiter #(
        .NUM_M (NUM_M),
        .IW    (MIW)
    ) u_arb (
        .req_i  (elig),
        .mode_i (RR_MODE),
        .ptr_i  (rr_ptr_q),
        .gnt_o  (arb_gnt),
        .idx_o  (win),
        .vld_o  (win_vld)
    );

    // One-hot mux of the winning master's request fields
    always_comb begin
        win_addr  = '0;
        win_wdata = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (arb_gnt[i]) begin
                win_addr  = m_addr_i[i*AW +: AW];
                win_wdata = m_wdata_i[i*DW +: DW];
            end
        end
    end

    assign win_we   = |(m_we_i & arb_gnt);
    assign win_lock = |(m_lock_i & arb_gnt);
    assign sel      = win_addr[AW-1 -: REGION_W];
    assign sel_ok   = int'(sel) < NUM_S;

    assign m_gnt_o  = arb_gnt;
    assign m_hold_o = rst_n ? (m_req_i & ~arb_gnt) : '0;

    // Request phase toward the slaves; an undecoded region strobes nobody
    always_comb begin
        s_req_o   = '0;
        s_we_o    = '0;
        s_addr_o  = '0;
        s_wdata_o = '0;
        for (int k = 0; k < NUM_S; k++) begin
            if (win_vld && int'(sel) == k) begin
                s_req_o[k]            = 1'b1;
                s_we_o[k]             = win_we;
                s_addr_o[k*AW +: AW]  = {{REGION_W{1'b0}}, win_addr[AW-REGION_W-1:0]};
                s_wdata_o[k*DW +: DW] = win_wdata;
            end
        end
    end

    // Response phase back to the owning master
    always_comb begin
        m_rvalid_o = '0;
        m_err_o    = '0;
        m_rdata_o  = '0;
        resp_data  = '0;
        for (int k = 0; k < NUM_S; k++) begin
            if (int'(cur_s_q) == k) begin
                resp_data = s_rdata_i[k*DW +: DW];
            end
        end
        if (state_q == ST_RESP) begin
            for (int i = 0; i < NUM_M; i++) begin
                if (int'(cur_m_q) == i) begin
                    m_rvalid_o[i]         = 1'b1;
                    m_err_o[i]            = cur_err_q;
                    m_rdata_o[i*DW +: DW] = cur_err_q ? '0 : resp_data;
                end
            end
        end
    end

    // Next state: a grant in either state pipelines straight into RESP
    always_comb begin
        state_d   = ST_IDLE;
        cur_m_d   = cur_m_q;
        cur_s_d   = cur_s_q;
        cur_err_d = cur_err_q;
        rr_ptr_d  = rr_ptr_q;
        if (win_vld) begin
            state_d   = ST_RESP;
            cur_m_d   = win;
            cur_s_d   = sel;
            cur_err_d = ~sel_ok;
            if (int'(win) == NUM_M - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = win + MIW'(1);
            end
        end
    end

    // Lock: an unlocked owner grant or the timeout releases; both can
    // coincide with a grant, which is still honoured this cycle.
    always_comb begin
        lock_d       = lock_q;
        lock_owner_d = lock_owner_q;
        lock_cnt_d   = lock_cnt_q;
        if (lock_q) begin
            if ((win_vld && !win_lock) || lock_cnt_q == CW'(LOCK_MAX - 1)) begin
                lock_d     = 1'b0;
                lock_cnt_d = '0;
            end else begin
                lock_cnt_d = lock_cnt_q + CW'(1);
            end
        end else if (win_vld && win_lock) begin
            lock_d       = 1'b1;
            lock_owner_d = win;
            lock_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cur_m_q      <= '0;
            cur_s_q      <= '0;
            cur_err_q    <= 1'b0;
            rr_ptr_q     <= '0;
            lock_q       <= 1'b0;
            lock_owner_q <= '0;
            lock_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            cur_m_q      <= cur_m_d;
            cur_s_q      <= cur_s_d;
            cur_err_q    <= cur_err_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            lock_cnt_q   <= lock_cnt_d;
        end
    end

endmodule

// File: tb/tb_bus_xbar_arb.sv
// tb/tb_bus_xbar_arb.sv - self-checking bench: fixed-priority and round-robin instances against a reference model
module tb_bus_xbar_arb;

    localparam int NM = 3;
    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LM = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NM-1:0]    req = '0, we = '0, lock = '0;
    logic [NM*AW-1:0] addr = '0;
    logic [NM*DW-1:0] wdata = '0;
    logic [NS*DW-1:0] srd = '0;

    logic [NM-1:0]    gnt [2];
    logic [NM-1:0]    hold [2];
    logic [NM-1:0]    rv [2];
    logic [NM-1:0]    err [2];
    logic [NM*DW-1:0] rdata [2];
    logic [NS-1:0]    sreq [2];
    logic [NS-1:0]    swe [2];
    logic [NS*AW-1:0] saddr [2];
    logic [NS*DW-1:0] swdata [2];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state per instance (0 = fixed priority, 1 = round robin)
    int rr [2];
    bit lk [2];
    int own [2];
    int cnt [2];
    bit pv [2];
    int pm [2];
    int ps [2];
    bit pe [2];

    always #5 clk = ~clk;

    for (genvar d = 0; d < 2; d++) begin : g_dut
        bus_xbar_arb #(
            .NUM_M(NM), .NUM_S(NS), .AW(AW), .DW(DW), .ARB_MODE(d), .LOCK_MAX(LM)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .m_req_i    (req),
            .m_we_i     (we),
            .m_lock_i   (lock),
            .m_addr_i   (addr),
            .m_wdata_i  (wdata),
            .m_gnt_o    (gnt[d]),
            .m_hold_o   (hold[d]),
            .m_rvalid_o (rv[d]),
            .m_err_o    (err[d]),
            .m_rdata_o  (rdata[d]),
            .s_req_o    (sreq[d]),
            .s_we_o     (swe[d]),
            .s_addr_o   (saddr[d]),
            .s_wdata_o  (swdata[d]),
            .s_rdata_i  (srd)
        );
    end

    // Winning master by the arbitration rules, or -1 if nobody is eligible
    function automatic int winner(input int d);
        int i;
        if (!rst_n) return -1;
        for (int k = 0; k < NM; k++) begin
            i = (d == 0) ? k : (rr[d] + k) % NM;
            if (req[i] && (!lk[d] || i == own[d])) return i;
        end
        return -1;
    endfunction

    task automatic set_m(input int i, input bit r, input bit w, input bit l,
                         input logic [31:0] a, input logic [31:0] dat);
        req[i] = r;
        we[i] = w;
        lock[i] = l;
        addr[i*AW +: AW] = a;
        wdata[i*DW +: DW] = dat;
    endtask

    task automatic clear_m();
        req = '0;
        we = '0;
        lock = '0;
    endtask

    // Let inputs settle, then compare both instances against the model
    task automatic settle();
        int w;
        int sel;
        logic [31:0] a;
        logic [NM-1:0] eg, eh, ev, ee;
        logic [NM*DW-1:0] erd;
        logic [NS-1:0] esr, esw;
        logic [NS*AW-1:0] esa;
        logic [NS*DW-1:0] esd;
        #2;
        for (int d = 0; d < 2; d++) begin
            eg = '0; ev = '0; ee = '0; erd = '0;
            esr = '0; esw = '0; esa = '0; esd = '0;
            w = winner(d);
            if (w >= 0) begin
                eg[w] = 1'b1;
                a = addr[w*AW +: AW];
                sel = int'(a[31:28]);
                if (sel < NS) begin
                    esr[sel] = 1'b1;
                    esw[sel] = we[w];
                    esa[sel*AW +: AW] = a & 32'h0FFF_FFFF;
                    esd[sel*DW +: DW] = wdata[w*DW +: DW];
                end
            end
            eh = rst_n ? (req & ~eg) : '0;
            if (rst_n && pv[d]) begin
                ev[pm[d]] = 1'b1;
                ee[pm[d]] = pe[d];
                erd[pm[d]*DW +: DW] = pe[d] ? 32'h0 : srd[ps[d]*DW +: DW];
            end
            n_cmp++;
            if ({gnt[d], hold[d], rv[d], err[d]} !== {eg, eh, ev, ee}) begin
                n_bad++;
                $display("FAIL model_master dut%0d t=%0t gnt/hold/rv/err got %b_%b_%b_%b expected %b_%b_%b_%b",
                         d, $time, gnt[d], hold[d], rv[d], err[d], eg, eh, ev, ee);
            end
            n_cmp++;
            if (rdata[d] !== erd) begin
                n_bad++;
                $display("FAIL model_rdata dut%0d t=%0t got %h expected %h", d, $time, rdata[d], erd);
            end
            n_cmp++;
            if ({sreq[d], swe[d]} !== {esr, esw}) begin
                n_bad++;
                $display("FAIL model_sreq dut%0d t=%0t req/we got %b_%b expected %b_%b",
                         d, $time, sreq[d], swe[d], esr, esw);
            end
            n_cmp++;
            if (saddr[d] !== esa) begin
                n_bad++;
                $display("FAIL model_saddr dut%0d t=%0t got %h expected %h", d, $time, saddr[d], esa);
            end
            n_cmp++;
            if (swdata[d] !== esd) begin
                n_bad++;
                $display("FAIL model_swdata dut%0d t=%0t got %h expected %h", d, $time, swdata[d], esd);
            end
        end
    endtask

    // Clock edge: advance the model with the inputs that were present at the edge
    task automatic tick();
        int w;
        logic [31:0] a;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                rr[d] = 0; lk[d] = 0; cnt[d] = 0; own[d] = 0; pv[d] = 0;
            end else begin
                w = winner(d);
                if (lk[d]) begin
                    if ((w >= 0 && !lock[w]) || cnt[d] == LM - 1) lk[d] = 0;
                    else cnt[d]++;
                end else if (w >= 0 && lock[w]) begin
                    lk[d] = 1; own[d] = w; cnt[d] = 0;
                end
                if (w >= 0) begin
                    a = addr[w*AW +: AW];
                    pv[d] = 1; pm[d] = w; ps[d] = int'(a[31:28]); pe[d] = (ps[d] >= NS);
                    rr[d] = (w + 1) % NM;
                end else begin
                    pv[d] = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear_m();
        rst_n = 1'b0;
        settle(); tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        set_m(0, 1, 0, 0, 32'h1000_0040, 32'h0);
        settle();
        n_cmp++;
        if (gnt[0] !== 3'b001) begin n_bad++; $display("FAIL reset_pre_gnt got %b expected 001", gnt[0]); end
        tick();
        rst_n = 1'b0;
        settle();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if ({gnt[d], hold[d], rv[d], sreq[d], rdata[d]} !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs dut%0d gnt=%b hold=%b rv=%b sreq=%b expected all 0", d, gnt[d], hold[d], rv[d], sreq[d]);
            end
        end
        tick(); tick();
        rst_n = 1'b1;
        clear_m();
        settle();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (rv[d] !== 3'b000) begin n_bad++; $display("FAIL reset_no_rvalid dut%0d got %b expected 000", d, rv[d]); end
        end
        tick();
        set_m(0, 1, 0, 0, 32'h0, 32'h0);
        set_m(1, 1, 0, 0, 32'h0, 32'h0);
        settle();
        n_cmp++;
        if (gnt[1] !== 3'b001) begin n_bad++; $display("FAIL reset_rr_ptr got %b expected 001", gnt[1]); end
        tick();
        clear_m();
        settle(); tick();
    endtask

    task automatic test_fixed_pipeline();
        do_reset();
        srd = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        set_m(0, 1, 0, 0, 32'h1000_0040, 32'h0);
        set_m(1, 1, 0, 0, 32'h0000_0000, 32'h0);
        settle();
        n_cmp++;
        if ({gnt[0], hold[0], sreq[0]} !== {3'b001, 3'b010, 4'b0010}) begin
            n_bad++; $display("FAIL pipe_first gnt/hold/sreq got %b/%b/%b expected 001/010/0010", gnt[0], hold[0], sreq[0]);
        end
        n_cmp++;
        if (saddr[0][63:32] !== 32'h0000_0040) begin n_bad++; $display("FAIL pipe_saddr got %h expected 00000040", saddr[0][63:32]); end
        tick();
        req[0] = 1'b0;
        settle();
        n_cmp++;
        if ({gnt[0], rv[0]} !== {3'b010, 3'b001}) begin n_bad++; $display("FAIL pipe_second gnt/rv got %b/%b expected 010/001", gnt[0], rv[0]); end
        n_cmp++;
        if (rdata[0][31:0] !== 32'hBBBB_0001) begin n_bad++; $display("FAIL pipe_rdata_m0 got %h expected bbbb0001", rdata[0][31:0]); end
        tick();
        clear_m();
        settle();
        n_cmp++;
        if ({rv[0], rdata[0][63:32]} !== {3'b010, 32'hAAAA_0000}) begin
            n_bad++; $display("FAIL pipe_rdata_m1 rv/rdata got %b/%h expected 010/aaaa0000", rv[0], rdata[0][63:32]);
        end
        tick();
    endtask

    task automatic test_rr_alternate();
        logic [NM-1:0] exp_g, prev_g;
        do_reset();
        set_m(0, 1, 0, 0, 32'h2000_0000, 32'h0);
        set_m(1, 1, 0, 0, 32'h2000_0004, 32'h0);
        prev_g = '0;
        for (int c = 0; c < 6; c++) begin
            settle();
            exp_g = (c % 2 == 0) ? 3'b001 : 3'b010;
            n_cmp++;
            if (gnt[1] !== exp_g) begin n_bad++; $display("FAIL rr_grant cycle %0d got %b expected %b", c, gnt[1], exp_g); end
            n_cmp++;
            if (rv[1] !== prev_g) begin n_bad++; $display("FAIL rr_rvalid cycle %0d got %b expected %b", c, rv[1], prev_g); end
            prev_g = exp_g;
            tick();
        end
        clear_m();
        settle();
        n_cmp++;
        if (rv[1] !== 3'b010) begin n_bad++; $display("FAIL rr_last_rvalid got %b expected 010", rv[1]); end
        tick();
    endtask

    task automatic test_decode_err();
        srd = {4{32'h5A5A_A5A5}};
        set_m(0, 1, 1, 0, 32'h5000_0010, 32'h1234_5678);
        settle();
        n_cmp++;
        if ({gnt[0], sreq[0]} !== {3'b001, 4'b0000}) begin n_bad++; $display("FAIL err_strobe gnt/sreq got %b/%b expected 001/0000", gnt[0], sreq[0]); end
        tick();
        clear_m();
        settle();
        n_cmp++;
        if ({rv[0], err[0], rdata[0]} !== {3'b001, 3'b001, 96'h0}) begin
            n_bad++; $display("FAIL err_resp rv/err/rdata got %b/%b/%h expected 001/001/0", rv[0], err[0], rdata[0]);
        end
        tick();
    endtask

    task automatic test_lock_release();
        do_reset();
        set_m(1, 1, 0, 1, 32'h2000_0100, 32'h0);
        settle();
        n_cmp++;
        if (gnt[0] !== 3'b010) begin n_bad++; $display("FAIL lock_first got %b expected 010", gnt[0]); end
        tick();
        for (int c = 1; c < 4; c++) begin
            set_m(0, 1, 0, 0, 32'h1000_0000, 32'h0);
            lock[1] = (c < 3);
            settle();
            n_cmp++;
            if ({gnt[0], hold[0]} !== {3'b010, 3'b001}) begin
                n_bad++; $display("FAIL lock_held cycle %0d gnt/hold got %b/%b expected 010/001", c, gnt[0], hold[0]);
            end
            tick();
        end
        req[1] = 1'b0;
        settle();
        n_cmp++;
        if (gnt[0] !== 3'b001) begin n_bad++; $display("FAIL lock_after got %b expected 001", gnt[0]); end
        tick();
        clear_m();
        settle(); tick();
    endtask

    task automatic test_lock_timeout();
        do_reset();
        set_m(1, 1, 0, 1, 32'h3000_0000, 32'h0);
        settle();
        n_cmp++;
        if (gnt[0] !== 3'b010) begin n_bad++; $display("FAIL tmo_first got %b expected 010", gnt[0]); end
        tick();
        req[1] = 1'b0;
        set_m(0, 1, 0, 0, 32'h0000_0008, 32'h0);
        for (int c = 1; c <= LM; c++) begin
            settle();
            n_cmp++;
            if ({gnt[0], hold[0]} !== {3'b000, 3'b001}) begin
                n_bad++; $display("FAIL tmo_blocked cycle %0d gnt/hold got %b/%b expected 000/001", c, gnt[0], hold[0]);
            end
            tick();
        end
        settle();
        n_cmp++;
        if (gnt[0] !== 3'b001) begin n_bad++; $display("FAIL tmo_release got %b expected 001", gnt[0]); end
        tick();
        clear_m();
        settle(); tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            req = NM'($urandom);
            we = NM'($urandom);
            for (int i = 0; i < NM; i++) begin
                lock[i] = ($urandom_range(0, 3) == 0);
                addr[i*AW +: AW] = {4'($urandom_range(0, 6)), 28'($urandom)};
                wdata[i*DW +: DW] = $urandom;
            end
            for (int k = 0; k < NS; k++) srd[k*DW +: DW] = $urandom;
            settle();
            tick();
        end
        rst_n = 1'b1;
        clear_m();
        settle(); tick();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_fixed_pipeline();
        test_rr_alternate();
        test_decode_err();
        test_lock_release();
        test_lock_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
